vend_ctrl_multi: RTL and testbench
==================================

Name: vend_ctrl_multi

Overview:
- Parametrised successor to the single-product coffee vending FSM: N products with per-product prices, coin credit accumulation, change payout and cancel/refund.
- Sits between the coin acceptor front end and the product dispenser.
- Coins use the existing 2-bit denomination encoding, 25p = 1 credit unit.
- Dispenser interface is a valid/ready handshake.

Parameters:
- N_PROD, 4, number of products (1..2**SEL_W).
- SEL_W, 2, width of product select.
- CW, 4, credit/price width in 25p units.
- PRICES, {4'd6,4'd3,4'd2,4'd4}, packed N_PROD*CW vector; product i price at bits [i*CW +: CW] (P0=4, P1=2, P2=3, P3=6).
- MAX_CREDIT, 12, credit ceiling in units (must be < 2**CW).
- TO_CYCLES, 16, dispense timeout; used only with VEND_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- coin_valid  in  1  one-cycle strobe; a coin is present.
- coin  in  2  denomination: 00=25p(1u), 01=50p(2u), 10=75p(3u), 11=1rs(4u).
- sel  in  SEL_W  product select, sampled with vend_req.
- vend_req  in  1  one-cycle purchase request.
- cancel  in  1  one-cycle refund request.
- disp_ready  in  1  dispenser accepts the product.
- disp_valid  out  1  dispense request, held until accepted.
- disp_id  out  SEL_W  product being dispensed.
- change_pulse  out  1  one pulse = one 25p unit returned.
- coin_reject  out  1  one-cycle pulse; coin not credited.
- vend_err  out  1  one-cycle pulse; bad select or insufficient credit.
- credit  out  CW  current credit in units.
- busy  out  1  high in DISPENSE or CHANGE.

Behaviour:
- Reset (rst low, async): state IDLE, credit 0, all outputs 0.
- Credit is lost on reset, including reset mid-DISPENSE or mid-CHANGE. disp_valid drops immediately.
- States:
  - IDLE: credit==0.
  - CREDIT: credit>0.
  - DISPENSE.
  - CHANGE.
- IDLE/CREDIT event priority per cycle: cancel > vend_req > coin_valid. Lower-priority events in the same cycle are dropped.
- Coins dropped this way, or arriving in DISPENSE/CHANGE, pulse coin_reject on the next cycle.
- Coin: if credit+value <= MAX_CREDIT, credit += value on the next edge. Otherwise pulse coin_reject and leave credit unchanged. Compute the sum at CW+1 bits.
- vend_req with sel < N_PROD and credit >= PRICES[sel]:
  - Next edge: credit -= price, disp_id <= sel, disp_valid <= 1, state DISPENSE.
  - Otherwise pulse vend_err; state and credit unchanged.
- DISPENSE: hold disp_valid and disp_id stable. On the edge where disp_ready=1, drop disp_valid and go to CHANGE if credit>0, else IDLE.
- cancel in CREDIT: go to CHANGE (full refund). cancel in IDLE is ignored. cancel in DISPENSE/CHANGE is ignored.
- CHANGE: change_pulse=1 every cycle. Credit decrements by 1 per cycle. On the cycle credit reaches 0, go to IDLE.
- A refund of K units gives exactly K consecutive pulses.
- credit is registered; it reflects the new value one cycle after the event.
- All pulse outputs are registered, one cycle wide.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined:
  - Counter runs in DISPENSE.
  - If disp_ready has not been seen after TO_CYCLES cycles: drop disp_valid, restore the price to credit, go to CHANGE (full refund).
  - Pulse extra output vend_fault for one cycle.
- Undefined: DISPENSE waits indefinitely. The vend_fault port and counter are absent.

Decomposition:
- Package vend_pkg contains:
  - Coin encoding localparams.
  - coin_value function (2-bit code -> unit count).
  - State enum/encoding (IDLE, CREDIT, DISPENSE, CHANGE).
- One sub-module: vend_change_payout, a load/decrement counter emitting change_pulse and a done flag, instantiated by the FSM.

Test Plan:
1. Four 25p coins, then vend_req sel=0 -> credit 1,2,3,4; disp_valid with disp_id=0; after disp_ready, zero change pulses, state IDLE, credit 0.
2. 1rs + 50p (credit 6), vend_req sel=2 -> credit 3, dispense id 2, then exactly 3 change_pulse cycles, credit 0.
3. Credit 12, then a 25p coin -> coin_reject pulse, credit stays 12. Credit 2, vend_req sel=3 -> vend_err pulse, credit stays 2.
4. Credit 5 with cancel and coin_valid in the same cycle -> coin_reject, then 5 change pulses, then IDLE.
5. Assert rst low mid-CHANGE (credit 3) -> immediately credit 0, change_pulse 0, IDLE. disp_ready held low in DISPENSE -> disp_valid held, id stable.
6. With VEND_TIMEOUT_EN: credit 4, buy P0, disp_ready held low for TO_CYCLES -> vend_fault pulse, 4 refund pulses, IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared coin encoding, coin value decode and controller state encoding
package vend_pkg;

    localparam logic [1:0] COIN_25  = 2'b00;
    localparam logic [1:0] COIN_50  = 2'b01;
    localparam logic [1:0] COIN_75  = 2'b10;
    localparam logic [1:0] COIN_1RS = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_CHANGE} state_t;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        return code == COIN_25 ? 3'd1 : code == COIN_50 ? 3'd2 : code == COIN_75 ? 3'd3 : 3'd4;
    endfunction

endpackage

// File: rtl/vend_change_payout.sv
// vend_change_payout: load/decrement counter emitting one change pulse per unit
// Ports: clk, rst (async active-low), i_load/i_load_val (start a refund of
// i_load_val units), o_cnt (units still owed), o_pulse (registered change pulse),
// o_done (last unit is being paid this cycle, or nothing is owed).
module vend_change_payout #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic [CW-1:0] o_cnt,
    output logic          o_pulse,
    output logic          o_done
);
    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    // A load of K produces K consecutive pulse cycles showing K..1 on o_cnt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_cnt   <= i_load ? i_load_val : r_cnt - CW'(r_cnt != '0);
            r_pulse <= i_load ? i_load_val != '0 : r_cnt > CW'(1);
        end
    end

    assign o_cnt   = r_cnt;
    assign o_pulse = r_pulse;
    assign o_done  = r_cnt <= CW'(1);

endmodule

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: N-product vending controller with credit, change payout and refund
// Ports: clk, rst (async active-low); coin_valid/coin from the coin acceptor;
// sel/vend_req purchase request; cancel refund request; disp_valid/disp_id/
// disp_ready dispenser handshake; change_pulse one per 25p unit returned;
// coin_reject/vend_err one-cycle pulses; credit in 25p units; busy in DISPENSE/CHANGE.
// Build option: define VEND_TIMEOUT_EN to add a dispense timeout with a full
// refund and the vend_fault pulse output.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                   N_PROD     = 4,
    parameter int                   SEL_W      = 2,
    parameter int                   CW         = 4,
    parameter logic [N_PROD*CW-1:0] PRICES     = {4'd6, 4'd3, 4'd2, 4'd4},
    parameter int                   MAX_CREDIT = 12,
    parameter int                   TO_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_valid,
    input  logic [1:0]       coin,
    input  logic [SEL_W-1:0] sel,
    input  logic             vend_req,
    input  logic             cancel,
    input  logic             disp_ready,
    output logic             disp_valid,
    output logic [SEL_W-1:0] disp_id,
    output logic             change_pulse,
    output logic             coin_reject,
    output logic             vend_err,
    output logic [CW-1:0]    credit,
`ifdef VEND_TIMEOUT_EN
    output logic             vend_fault,
`endif
    output logic             busy
);
    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_credit, w_price, w_load_val, w_pay_cnt;
    logic [CW:0]      w_coin_sum;
    logic [SEL_W-1:0] r_disp_id;
    logic             r_disp_valid, r_coin_reject, r_vend_err;
    logic             w_open, w_cancel, w_vend, w_vend_ok, w_coin_ok;
    logic             w_pay_load, w_pay_done, w_timeout;
    logic [CW-1:0]    w_price_tab [2**SEL_W];

    // Unpopulated select codes read as price 0 but are rejected by the range check.
    for (genvar i = 0; i < 2**SEL_W; i++) begin : g_price
        if (i < N_PROD) begin : g_p
            assign w_price_tab[i] = PRICES[i*CW +: CW];
        end else begin : g_z
            assign w_price_tab[i] = '0;
        end
    end

    assign w_price    = w_price_tab[sel];
    assign w_coin_sum = {1'b0, r_credit} + (CW+1)'(coin_value(coin));
    // Only IDLE/CREDIT accept events; cancel with zero credit is a no-op so it
    // does not shadow lower-priority events.
    assign w_open     = r_state == S_IDLE || r_state == S_CREDIT;
    assign w_cancel   = w_open && cancel && r_credit != '0;
    assign w_vend     = w_open && !w_cancel && vend_req;
    assign w_vend_ok  = w_vend && int'(sel) < N_PROD && r_credit >= w_price;
    assign w_coin_ok  = w_open && !w_cancel && !vend_req && coin_valid &&
                        w_coin_sum <= (CW+1)'(MAX_CREDIT);
    assign w_pay_load = r_state != S_CHANGE && w_state_nxt == S_CHANGE;

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_vend_fault;

    assign w_timeout  = r_state == S_DISPENSE && !disp_ready && r_to_cnt == TO_W'(TO_CYCLES - 1);
    // A timed-out vend refunds the price that was already deducted.
    assign w_load_val = w_timeout ? r_credit + w_price_tab[r_disp_id] : r_credit;
    assign vend_fault = r_vend_fault;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt     <= '0;
            r_vend_fault <= 1'b0;
        end else begin
            r_to_cnt     <= r_state == S_DISPENSE ? r_to_cnt + TO_W'(1) : '0;
            r_vend_fault <= w_timeout;
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign w_load_val = r_credit;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_CREDIT: w_state_nxt = w_cancel ? S_CHANGE : w_vend_ok ? S_DISPENSE :
                                            w_coin_ok ? S_CREDIT : r_state;
            S_DISPENSE:       w_state_nxt = w_timeout || (disp_ready && r_credit != '0) ? S_CHANGE :
                                            disp_ready ? S_IDLE : S_DISPENSE;
            S_CHANGE:         w_state_nxt = w_pay_done ? S_IDLE : S_CHANGE;
            default:          w_state_nxt = S_IDLE;
        endcase
    end

    // Credit owed as change moves into the payout counter, so r_credit clears on load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit      <= '0;
            r_disp_id     <= '0;
            r_disp_valid  <= 1'b0;
            r_coin_reject <= 1'b0;
            r_vend_err    <= 1'b0;
        end else begin
            r_credit      <= w_pay_load ? '0 : w_vend_ok ? r_credit - w_price :
                             w_coin_ok ? w_coin_sum[CW-1:0] : r_credit;
            r_disp_id     <= w_vend_ok ? sel : r_disp_id;
            r_disp_valid  <= w_state_nxt == S_DISPENSE;
            r_coin_reject <= coin_valid && !w_coin_ok;
            r_vend_err    <= w_vend && !w_vend_ok;
        end
    end

    vend_change_payout #(.CW(CW)) u_payout (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pay_load),
        .i_load_val (w_load_val),
        .o_cnt      (w_pay_cnt),
        .o_pulse    (change_pulse),
        .o_done     (w_pay_done)
    );

    assign credit      = r_state == S_CHANGE ? w_pay_cnt : r_credit;
    assign busy        = r_state == S_DISPENSE || r_state == S_CHANGE;
    assign disp_valid  = r_disp_valid;
    assign disp_id     = r_disp_id;
    assign coin_reject = r_coin_reject;
    assign vend_err    = r_vend_err;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi: directed and random checks against a transaction-level vending model
module tb_vend_ctrl_multi;
    logic       clk = 1'b0, rst = 1'b0;
    logic       coin_valid = 1'b0, vend_req = 1'b0, cancel = 1'b0, disp_ready = 1'b0;
    logic [1:0] coin = 2'd0, sel = 2'd0;
    logic       disp_valid, change_pulse, coin_reject, vend_err, busy;
    logic [1:0] disp_id;
    logic [3:0] credit;
`ifdef VEND_TIMEOUT_EN
    logic       vend_fault;
`endif

    int n_cmp = 0, n_bad = 0;

    // Model: money held, whether a product is out for dispense, and units still owed.
    int price [4] = '{4, 2, 3, 6};
    int m_credit, m_refund, m_wait, m_id;
    bit m_disp, e_rej, e_err, e_fault;

    always #5 clk = ~clk;

    vend_ctrl_multi dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin         (coin),
        .sel          (sel),
        .vend_req     (vend_req),
        .cancel       (cancel),
        .disp_ready   (disp_ready),
        .disp_valid   (disp_valid),
        .disp_id      (disp_id),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .vend_err     (vend_err),
        .credit       (credit),
`ifdef VEND_TIMEOUT_EN
        .vend_fault   (vend_fault),
`endif
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_refund = 0; m_wait = 0; m_id = 0; m_disp = 0;
        e_rej = 0; e_err = 0; e_fault = 0;
    endtask

    task automatic model_step();
        int val;
        val = int'(coin) + 1;
        e_rej = 0; e_err = 0; e_fault = 0;
        if (m_refund > 0) begin
            m_refund--;
            e_rej = coin_valid;
        end else if (m_disp) begin
            e_rej = coin_valid;
            if (disp_ready) begin
                m_disp = 0; m_refund = m_credit; m_credit = 0;
            end else begin
                m_wait++;
`ifdef VEND_TIMEOUT_EN
                if (m_wait == 16) begin
                    m_disp = 0; m_refund = m_credit + price[m_id]; m_credit = 0; e_fault = 1;
                end
`endif
            end
        end else if (cancel && m_credit > 0) begin
            m_refund = m_credit; m_credit = 0;
            e_rej = coin_valid;
        end else if (vend_req) begin
            if (m_credit >= price[sel]) begin
                m_credit -= price[sel]; m_disp = 1; m_id = int'(sel); m_wait = 0;
            end else e_err = 1;
            e_rej = coin_valid;
        end else if (coin_valid) begin
            if (m_credit + val <= 12) m_credit += val;
            else e_rej = 1;
        end
    endtask

    task automatic check_all();
        chk("disp_valid", disp_valid, m_disp);
        chk("disp_id", disp_id, m_id);
        chk("change_pulse", change_pulse, m_refund > 0);
        chk("coin_reject", coin_reject, e_rej);
        chk("vend_err", vend_err, e_err);
        chk("credit", credit, m_refund > 0 ? m_refund : m_credit);
        chk("busy", busy, m_disp || m_refund > 0);
`ifdef VEND_TIMEOUT_EN
        chk("vend_fault", vend_fault, e_fault);
`endif
    endtask

    task automatic drive(input bit cv, input logic [1:0] c, input bit vr, input logic [1:0] s,
                         input bit cn, input bit rdy);
        coin_valid = cv; coin = c; vend_req = vr; sel = s; cancel = cn; disp_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        coin_valid = 0; vend_req = 0; cancel = 0; disp_ready = 0;
    endtask

    task automatic idle();
        drive(0, 2'd0, 0, 2'd0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && busy; i++) drive(0, 2'd0, 0, 2'd0, 0, 1);
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;
        idle();

        // 1: four 25p coins, buy P0 (price 4), no change
        for (int i = 1; i <= 4; i++) begin
            drive(1, 2'd0, 0, 2'd0, 0, 0);
            chk("t1_credit", credit, i);
        end
        drive(0, 2'd0, 1, 2'd0, 0, 0);
        chk("t1_disp_valid", disp_valid, 1);
        drive(0, 2'd0, 0, 2'd0, 0, 1);
        chk("t1_change", change_pulse, 0);
        chk("t1_busy", busy, 0);

        // 2: 1rs + 50p, buy P2 (price 3), three change pulses
        drive(1, 2'd3, 0, 2'd0, 0, 0);
        drive(1, 2'd1, 0, 2'd0, 0, 0);
        chk("t2_credit6", credit, 6);
        drive(0, 2'd0, 1, 2'd2, 0, 0);
        chk("t2_credit3", credit, 3);
        chk("t2_id", disp_id, 2);
        drive(0, 2'd0, 0, 2'd0, 0, 1);
        n = 0;
        while (change_pulse && n < 20) begin n++; idle(); end
        chk("t2_pulses", n, 3);
        chk("t2_credit0", credit, 0);

        // 3: over-ceiling coin rejected; insufficient credit vend error
        repeat (3) drive(1, 2'd3, 0, 2'd0, 0, 0);
        drive(1, 2'd0, 0, 2'd0, 0, 0);
        chk("t3_reject", coin_reject, 1);
        chk("t3_credit12", credit, 12);
        drive(0, 2'd0, 0, 2'd0, 1, 0);
        drain();
        drive(1, 2'd1, 0, 2'd0, 0, 0);
        drive(0, 2'd0, 1, 2'd3, 0, 0);
        chk("t3_vend_err", vend_err, 1);
        chk("t3_credit2", credit, 2);
        drive(0, 2'd0, 0, 2'd0, 1, 0);
        drain();

        // 4: cancel beats a coin in the same cycle; five refund pulses
        drive(1, 2'd3, 0, 2'd0, 0, 0);
        drive(1, 2'd0, 0, 2'd0, 0, 0);
        drive(1, 2'd2, 0, 2'd0, 1, 0);
        chk("t4_reject", coin_reject, 1);
        n = 0;
        while (change_pulse && n < 20) begin n++; idle(); end
        chk("t4_pulses", n, 5);
        chk("t4_busy", busy, 0);

        // 5: async reset during refund, then a stalled dispenser
        drive(1, 2'd1, 0, 2'd0, 0, 0);
        drive(1, 2'd0, 0, 2'd0, 0, 0);
        drive(0, 2'd0, 0, 2'd0, 1, 0);
        chk("t5_in_change", change_pulse, 1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_credit", credit, 0);
        chk("t5_rst_change", change_pulse, 0);
        chk("t5_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 2'd3, 0, 2'd0, 0, 0);
        drive(0, 2'd0, 1, 2'd1, 0, 0);
        repeat (5) idle();
        chk("t5_hold_valid", disp_valid, 1);
        chk("t5_hold_id", disp_id, 1);
        drive(0, 2'd0, 0, 2'd0, 0, 1);
        drain();

`ifdef VEND_TIMEOUT_EN
        // 6: dispenser never ready -> fault and full refund
        drive(1, 2'd3, 0, 2'd0, 0, 0);
        drive(0, 2'd0, 1, 2'd0, 0, 0);
        repeat (16) idle();
        chk("t6_fault", vend_fault, 1);
        n = 0;
        while (change_pulse && n < 20) begin n++; idle(); end
        chk("t6_pulses", n, 4);
        chk("t6_busy", busy, 0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(9) < 3, 2'($urandom_range(3)), $urandom_range(9) == 0,
                  2'($urandom_range(3)), $urandom_range(19) == 0, $urandom_range(9) < 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
